// File: rtl/serializer_sched_if.sv
// rtl/serializer_sched_if.sv - request and serializer bus bundle for serializer_sched
// Ports (named from the scheduler's point of view):
//   req_valid_i  [NUM_CH]     per-channel frame request
//   req_data_i   [NUM_CH*27]  channel k payload at [27k+26:27k]
//   req_ready_o  [NUM_CH]     one-hot grant
//   ser_start_o               one-cycle start pulse to the serializer
//   ser_data_o   [27]         captured payload, three {k, byte} symbols
//   ser_ena_i                 serializer symbol strobe
// Modports: slave = scheduler, master = requesters plus serializer.
interface serializer_sched_if #(
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0]    req_valid_i;
    logic [NUM_CH*27-1:0] req_data_i;
    logic [NUM_CH-1:0]    req_ready_o;
    logic                 ser_start_o;
    logic [26:0]          ser_data_o;
    logic                 ser_ena_i;

    modport master (
        output req_valid_i,
        output req_data_i,
        output ser_ena_i,
        input  req_ready_o,
        input  ser_start_o,
        input  ser_data_o
    );

    modport slave (
        input  req_valid_i,
        input  req_data_i,
        input  ser_ena_i,
        output req_ready_o,
        output ser_start_o,
        output ser_data_o
    );
endinterface

// File: rtl/serializer_sched.sv
// rtl/serializer_sched.sv - round-robin frame scheduler for the 27-bit symbol serializer
// Ports:
//   clk_i, rst_ni  clock (rising edge) and asynchronous active-low reset
//   en_i           allows new grants; an in-flight frame always completes
//   bus            serializer_sched_if.slave: requests, grant, serializer start/data/strobe
//   busy_o         high whenever the FSM is not IDLE
//   grant_id_o     channel index of the current or last frame
//   frame_done_o   one-cycle pulse after the 4th symbol strobe of a frame
//   frame_cnt_o    completed-frame count, wraps at 16 bits
module serializer_sched #(
    parameter int NUM_CH   = 2,
    parameter int GAP_SYMS = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      en_i,
    serializer_sched_if.slave         bus,
    output logic                      busy_o,
    output logic [$clog2(NUM_CH)-1:0] grant_id_o,
    output logic                      frame_done_o,
    output logic [15:0]               frame_cnt_o
);
    localparam int IDW = $clog2(NUM_CH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    localparam logic [3:0] GAP_LAST = (GAP_SYMS > 0) ? 4'(GAP_SYMS - 1) : 4'd0;

    logic [1:0]     state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] grant_id_q, grant_id_d;
    logic [26:0]    data_q, data_d;
    logic [1:0]     sym_cnt_q, sym_cnt_d;
    logic [3:0]     gap_cnt_q, gap_cnt_d;
    logic           done_q, done_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;

    logic [IDW-1:0] sel_idx;
    logic [IDW-1:0] cand;
    logic           sel_found;
    logic           grant;

    // (base + offs) mod NUM_CH for offs < NUM_CH, also correct when NUM_CH is not a power of two
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_CH) begin
            s = s - NUM_CH;
        end
        return IDW'(s);
    endfunction

    // First valid channel at or after the round-robin pointer
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand = wrap_idx(rr_q, i);
            if (!sel_found && bus.req_valid_i[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    // Ready is gated by reset so the grant stays low while the block is held in reset
    assign grant = rst_ni && en_i && sel_found && (state_q == ST_IDLE);

    always_comb begin
        bus.req_ready_o = '0;
        if (grant) begin
            bus.req_ready_o[sel_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        grant_id_d  = grant_id_q;
        data_d      = data_q;
        sym_cnt_d   = sym_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        done_d      = 1'b0;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (grant) begin
                    data_d     = bus.req_data_i[27*int'(sel_idx) +: 27];
                    grant_id_d = sel_idx;
                    rr_d       = wrap_idx(sel_idx, 1);
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                // A strobe landing here belongs to no symbol of this frame
                sym_cnt_d = '0;
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.ser_ena_i) begin
                    sym_cnt_d = sym_cnt_q + 2'd1;
                    if (sym_cnt_q == 2'd3) begin
                        done_d      = 1'b1;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                        gap_cnt_d   = '0;
                        state_d     = (GAP_SYMS == 0) ? ST_IDLE : ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (bus.ser_ena_i) begin
                    gap_cnt_d = gap_cnt_q + 4'd1;
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            grant_id_q  <= '0;
            data_q      <= '0;
            sym_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            done_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            grant_id_q  <= grant_id_d;
            data_q      <= data_d;
            sym_cnt_q   <= sym_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            done_q      <= done_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus.ser_start_o = (state_q == ST_START);
    assign bus.ser_data_o  = data_q;
    assign busy_o          = (state_q != ST_IDLE);
    assign grant_id_o      = grant_id_q;
    assign frame_done_o    = done_q;
    assign frame_cnt_o     = frame_cnt_q;
endmodule
